// File: rtl/ntt_core_wmm_dispatch_rotate_wr_mpcg_if.sv
// Beat bus of the NTT dispatch/rotate block: input beat plus its dispatched, aligned output.
// The slave modport is the dispatcher side; the master modport is the beat source/sink side.
interface ntt_core_wmm_dispatch_rotate_wr_mpcg_if #(
    parameter int unsigned N_LANE = 16,
    parameter int unsigned OP_W   = 32,
    parameter int unsigned ROT_W  = 4
);
    logic [N_LANE*OP_W-1:0] in_data;
    logic                   in_vld;
    logic                   in_sob;
    logic                   in_eob;
    logic                   in_mode;
    logic [ROT_W-1:0]       in_rot;
    logic                   in_tr_en;

    logic [N_LANE*OP_W-1:0] out_data;
    logic                   out_vld;
    logic                   out_sob;
    logic                   out_eob;
    logic                   out_err;

    modport master (
        output in_data, in_vld, in_sob, in_eob, in_mode, in_rot, in_tr_en,
        input  out_data, out_vld, out_sob, out_eob, out_err
    );

    modport slave (
        input  in_data, in_vld, in_sob, in_eob, in_mode, in_rot, in_tr_en,
        output out_data, out_vld, out_sob, out_eob, out_err
    );
endinterface

// File: rtl/ntt_core_wmm_dispatch_rotate_wr_mpcg.sv
// NTT coefficient dispatcher: per-beat lane rotation, optional R x PSI transpose and a
// three-stage pipeline whose registers are individually bypassable, plus batch framing check.
module ntt_core_wmm_dispatch_rotate_wr_mpcg #(
    parameter int unsigned R           = 2,
    parameter int unsigned PSI         = 8,
    parameter int unsigned OP_W        = 32,
    parameter logic [2:0]  LAT_PIPE_MH = 3'b111,
    parameter int unsigned ROT_STEP    = 1,
    localparam int unsigned N_LANE     = R * PSI,
    localparam int unsigned ROT_W      = (N_LANE > 1) ? $clog2(N_LANE) : 1
) (
    input logic clk,
    input logic a_rst_n,
    ntt_core_wmm_dispatch_rotate_wr_mpcg_if.slave bus
);

    typedef logic [N_LANE*OP_W-1:0] data_t;

    typedef struct packed {
        logic vld;
        logic sob;
        logic eob;
    } ctrl_t;

    typedef enum logic [0:0] {StIdle, StOpen} state_e;

    // Right rotation: out lane i takes input lane (i + amt) mod N_LANE.
    function automatic data_t rotate(input data_t d, input logic [ROT_W-1:0] amt);
        data_t            o;
        logic [ROT_W-1:0] src;
        o = '0;
        for (int unsigned i = 0; i < N_LANE; i++) begin
            src = ROT_W'(i) + amt;
            o[i*OP_W +: OP_W] = d[(int'(src) % N_LANE)*OP_W +: OP_W];
        end
        return o;
    endfunction

    function automatic data_t transpose(input data_t d);
        data_t o;
        o = '0;
        for (int unsigned p = 0; p < PSI; p++) begin
            for (int unsigned r = 0; r < R; r++) begin
                o[(p*R + r)*OP_W +: OP_W] = d[(r*PSI + p)*OP_W +: OP_W];
            end
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Rotation counter and batch framing FSM
    // ------------------------------------------------------------------
    state_e           state_d, state_q;
    logic             err_d, err_q;
    logic [ROT_W-1:0] rot_cnt_d, rot_cnt_q;
    logic [ROT_W-1:0] rot_eff;

    always_comb begin
        if (bus.in_mode) begin
            rot_eff = bus.in_rot;
        end else if (bus.in_sob) begin
            rot_eff = '0;
        end else begin
            rot_eff = rot_cnt_q;
        end
    end

    always_comb begin
        rot_cnt_d = rot_cnt_q;
        if (bus.in_vld) begin
            if (!bus.in_mode) begin
                rot_cnt_d = rot_eff + ROT_W'(ROT_STEP);
            end else if (bus.in_sob) begin
                rot_cnt_d = '0;
            end
        end
    end

    // An sob seen while open flags the error but keeps the batch open unless eob closes it.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (bus.in_vld) begin
            case (state_q)
                StIdle: begin
                    if (!bus.in_sob) begin
                        err_d = 1'b1;
                    end else if (!bus.in_eob) begin
                        state_d = StOpen;
                    end
                end
                StOpen: begin
                    if (bus.in_sob) begin
                        err_d = 1'b1;
                    end
                    if (bus.in_eob) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q   <= StIdle;
            err_q     <= 1'b0;
            rot_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            rot_cnt_q <= rot_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // S0: rotation (combinational from the inputs)
    // ------------------------------------------------------------------
    ctrl_t s0_ctrl;
    logic  s0_tr;
    data_t s0_data;

    always_comb begin
        s0_ctrl.vld = bus.in_vld;
        s0_ctrl.sob = bus.in_vld & bus.in_sob;
        s0_ctrl.eob = bus.in_vld & bus.in_eob;
        s0_tr       = bus.in_tr_en;
        s0_data     = rotate(bus.in_data, rot_eff);
    end

    // ------------------------------------------------------------------
    // S0_S1 stage: carries tr_en so the transpose follows its own beat
    // ------------------------------------------------------------------
    ctrl_t s1_ctrl;
    logic  s1_tr;
    data_t s1_data;

    if (LAT_PIPE_MH[0]) begin : g_s1_reg
        ctrl_t ctrl_d, ctrl_q;
        logic  tr_d, tr_q;
        data_t data_d, data_q;

        always_comb begin
            ctrl_d = s0_ctrl;
            tr_d   = s0_ctrl.vld ? s0_tr : tr_q;
            data_d = s0_ctrl.vld ? s0_data : data_q;
        end

        always_ff @(posedge clk or negedge a_rst_n) begin
            if (!a_rst_n) begin
                ctrl_q <= '0;
                tr_q   <= 1'b0;
            end else begin
                ctrl_q <= ctrl_d;
                tr_q   <= tr_d;
            end
        end

        always_ff @(posedge clk) begin
            data_q <= data_d;
        end

        assign s1_ctrl = ctrl_q;
        assign s1_tr   = tr_q;
        assign s1_data = data_q;
    end else begin : g_s1_wire
        assign s1_ctrl = s0_ctrl;
        assign s1_tr   = s0_tr;
        assign s1_data = s0_data;
    end

    // ------------------------------------------------------------------
    // S1_S2 stage: optional R x PSI transpose
    // ------------------------------------------------------------------
    data_t s2_in;
    ctrl_t s2_ctrl;
    data_t s2_data;

    always_comb begin
        s2_in = s1_tr ? transpose(s1_data) : s1_data;
    end

    if (LAT_PIPE_MH[1]) begin : g_s2_reg
        ctrl_t ctrl_d, ctrl_q;
        data_t data_d, data_q;

        always_comb begin
            ctrl_d = s1_ctrl;
            data_d = s1_ctrl.vld ? s2_in : data_q;
        end

        always_ff @(posedge clk or negedge a_rst_n) begin
            if (!a_rst_n) begin
                ctrl_q <= '0;
            end else begin
                ctrl_q <= ctrl_d;
            end
        end

        always_ff @(posedge clk) begin
            data_q <= data_d;
        end

        assign s2_ctrl = ctrl_q;
        assign s2_data = data_q;
    end else begin : g_s2_wire
        assign s2_ctrl = s1_ctrl;
        assign s2_data = s2_in;
    end

    // ------------------------------------------------------------------
    // S2_S3 stage: plain register to the outputs
    // ------------------------------------------------------------------
    ctrl_t s3_ctrl;
    data_t s3_data;

    if (LAT_PIPE_MH[2]) begin : g_s3_reg
        ctrl_t ctrl_d, ctrl_q;
        data_t data_d, data_q;

        always_comb begin
            ctrl_d = s2_ctrl;
            data_d = s2_ctrl.vld ? s2_data : data_q;
        end

        always_ff @(posedge clk or negedge a_rst_n) begin
            if (!a_rst_n) begin
                ctrl_q <= '0;
            end else begin
                ctrl_q <= ctrl_d;
            end
        end

        always_ff @(posedge clk) begin
            data_q <= data_d;
        end

        assign s3_ctrl = ctrl_q;
        assign s3_data = data_q;
    end else begin : g_s3_wire
        assign s3_ctrl = s2_ctrl;
        assign s3_data = s2_data;
    end

    assign bus.out_data = s3_data;
    assign bus.out_vld  = s3_ctrl.vld;
    assign bus.out_sob  = s3_ctrl.sob;
    assign bus.out_eob  = s3_ctrl.eob;
    assign bus.out_err  = err_q;

endmodule

// File: tb/tb_ntt_core_wmm_dispatch_rotate_wr_mpcg.sv
// Bench for the NTT dispatcher: three pipeline-mask variants share one stimulus stream and are
// compared against a lane-array reference model of rotation, transpose, latency and framing.
module tb_ntt_core_wmm_dispatch_rotate_wr_mpcg;

    localparam int NL   = 16;
    localparam int STEP = 1;

    logic           clk;
    logic           a_rst_n;
    logic [511:0]   din;
    logic           in_vld, in_sob, in_eob, in_mode, in_tr_en;
    logic [3:0]     in_rot;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int           cyc      = 0;
    int           rst_base = 0;
    int           cnt_m    = 0;
    bit           open_m   = 0;
    logic         err_m    = 0;
    logic         hv [0:1023];
    logic         hs [0:1023];
    logic         he [0:1023];
    logic [511:0] hd [0:1023];
    logic [31:0]  lin [NL];
    logic [511:0] seen_a [$];

    ntt_core_wmm_dispatch_rotate_wr_mpcg_if #(.N_LANE(16), .OP_W(32), .ROT_W(4)) ifa ();
    ntt_core_wmm_dispatch_rotate_wr_mpcg_if #(.N_LANE(16), .OP_W(32), .ROT_W(4)) ifb ();
    ntt_core_wmm_dispatch_rotate_wr_mpcg_if #(.N_LANE(16), .OP_W(32), .ROT_W(4)) ifc ();

    assign ifa.in_data = din;     assign ifb.in_data = din;     assign ifc.in_data = din;
    assign ifa.in_vld = in_vld;   assign ifb.in_vld = in_vld;   assign ifc.in_vld = in_vld;
    assign ifa.in_sob = in_sob;   assign ifb.in_sob = in_sob;   assign ifc.in_sob = in_sob;
    assign ifa.in_eob = in_eob;   assign ifb.in_eob = in_eob;   assign ifc.in_eob = in_eob;
    assign ifa.in_mode = in_mode; assign ifb.in_mode = in_mode; assign ifc.in_mode = in_mode;
    assign ifa.in_rot = in_rot;   assign ifb.in_rot = in_rot;   assign ifc.in_rot = in_rot;
    assign ifa.in_tr_en = in_tr_en;
    assign ifb.in_tr_en = in_tr_en;
    assign ifc.in_tr_en = in_tr_en;

    ntt_core_wmm_dispatch_rotate_wr_mpcg #(.LAT_PIPE_MH(3'b111)) u_dut_a (
        .clk(clk), .a_rst_n(a_rst_n), .bus(ifa.slave)
    );
    ntt_core_wmm_dispatch_rotate_wr_mpcg #(.LAT_PIPE_MH(3'b000)) u_dut_b (
        .clk(clk), .a_rst_n(a_rst_n), .bus(ifb.slave)
    );
    ntt_core_wmm_dispatch_rotate_wr_mpcg #(.LAT_PIPE_MH(3'b101)) u_dut_c (
        .clk(clk), .a_rst_n(a_rst_n), .bus(ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_dut(input string nm, input int lat, input logic ov, input logic os,
                           input logic oe, input logic oerr, input logic [511:0] od);
        int   idx;
        logic ev, es, ee;
        idx = cyc - lat;
        if (idx >= rst_base) begin
            ev = hv[idx]; es = hs[idx]; ee = he[idx];
        end else begin
            ev = 1'b0; es = 1'b0; ee = 1'b0;
        end
        chk({nm, ".vld"}, 512'(ov), 512'(ev));
        chk({nm, ".sob"}, 512'(os), 512'(es));
        chk({nm, ".eob"}, 512'(oe), 512'(ee));
        chk({nm, ".err"}, 512'(oerr), 512'(err_m));
        if (ev) chk({nm, ".data"}, od, hd[idx]);
    endtask

    // One clock cycle: drive at the falling edge, predict, sample 1 ns later, advance model.
    task automatic step(input bit v, input bit s, input bit e, input bit m,
                        input logic [3:0] r, input bit t, input bit rnd);
        int           rot;
        logic [31:0]  l1 [NL];
        logic [511:0] expv;
        @(negedge clk);
        for (int i = 0; i < NL; i++) begin
            lin[i] = rnd ? 32'($urandom) : 32'(i);
            din[i*32 +: 32] = lin[i];
        end
        in_vld = v; in_sob = s; in_eob = e; in_mode = m; in_rot = r; in_tr_en = t;

        rot = m ? int'(r) : (s ? 0 : cnt_m);
        for (int i = 0; i < NL; i++) l1[i] = lin[(i + rot) % NL];
        expv = '0;
        for (int p = 0; p < 8; p++) begin
            for (int q = 0; q < 2; q++) begin
                expv[(p*2 + q)*32 +: 32] = t ? l1[q*8 + p] : l1[p*2 + q];
            end
        end
        hv[cyc] = v; hs[cyc] = v & s; he[cyc] = v & e; hd[cyc] = expv;

        #1;
        chk_dut("p111", 3, ifa.out_vld, ifa.out_sob, ifa.out_eob, ifa.out_err, ifa.out_data);
        chk_dut("p000", 0, ifb.out_vld, ifb.out_sob, ifb.out_eob, ifb.out_err, ifb.out_data);
        chk_dut("p101", 2, ifc.out_vld, ifc.out_sob, ifc.out_eob, ifc.out_err, ifc.out_data);
        if (ifa.out_vld) seen_a.push_back(ifa.out_data);

        if (v) begin
            if (!m) cnt_m = (rot + STEP) % NL;
            else if (s) cnt_m = 0;
            if (!open_m) begin
                if (!s) err_m = 1'b1;
                else if (!e) open_m = 1'b1;
            end else begin
                if (s) err_m = 1'b1;
                if (e) open_m = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 4'd0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        in_vld = 0; in_sob = 0; in_eob = 0;
        #1 a_rst_n = 1'b0;
        #1;
        chk("rst.a.vld", 512'(ifa.out_vld), 512'(0));
        chk("rst.a.err", 512'(ifa.out_err), 512'(0));
        chk("rst.b.vld", 512'(ifb.out_vld), 512'(0));
        chk("rst.c.vld", 512'(ifc.out_vld), 512'(0));
        chk("rst.c.sob", 512'(ifc.out_sob), 512'(0));
        chk("rst.c.eob", 512'(ifc.out_eob), 512'(0));
        @(negedge clk);
        @(negedge clk);
        a_rst_n = 1'b1;
        cnt_m = 0; open_m = 0; err_m = 0; rst_base = cyc;
        seen_a.delete();
    endtask

    initial begin
        a_rst_n = 1'b0;
        din = '0; in_vld = 0; in_sob = 0; in_eob = 0; in_mode = 0; in_rot = 0; in_tr_en = 0;
        #1;
        chk("init.a.vld", 512'(ifa.out_vld), 512'(0));
        chk("init.a.err", 512'(ifa.out_err), 512'(0));
        chk("init.c.vld", 512'(ifc.out_vld), 512'(0));
        @(negedge clk);
        @(negedge clk);
        a_rst_n = 1'b1;

        // Four-beat auto batch, identity lanes
        step(1, 1, 0, 0, 4'd0, 0, 0);
        step(1, 0, 0, 0, 4'd0, 0, 0);
        step(1, 0, 0, 0, 4'd0, 0, 0);
        step(1, 0, 1, 0, 4'd0, 0, 0);
        idle(3);
        chk("b4.count", 512'(seen_a.size()), 512'(4));
        for (int k = 0; k < 4; k++) chk($sformatf("b4.lane0_%0d", k), 512'(seen_a[k][31:0]),
                                        512'(k));

        // Explicit rotation by 15
        seen_a.delete();
        step(1, 1, 1, 1, 4'd15, 0, 0);
        idle(3);
        chk("rot15.lane0", 512'(seen_a[0][31:0]), 512'(15));
        chk("rot15.lane1", 512'(seen_a[0][63:32]), 512'(0));

        // Transpose with rotation 0
        seen_a.delete();
        step(1, 1, 1, 1, 4'd0, 1, 0);
        idle(3);
        chk("tr.lane0", 512'(seen_a[0][31:0]), 512'(0));
        chk("tr.lane1", 512'(seen_a[0][63:32]), 512'(8));
        chk("tr.lane2", 512'(seen_a[0][95:64]), 512'(1));
        chk("tr.lane3", 512'(seen_a[0][127:96]), 512'(9));

        // Beat without sob while idle: sticky error
        step(1, 0, 0, 0, 4'd0, 0, 0);
        idle(1);
        chk("err.idle_nosob", 512'(ifa.out_err), 512'(1));
        idle(3);
        chk("err.sticky", 512'(ifc.out_err), 512'(1));

        // sob inside an open batch: error, rotation restarts at 0
        do_reset();
        step(1, 1, 0, 0, 4'd0, 0, 0);
        step(1, 0, 0, 0, 4'd0, 0, 0);
        step(1, 1, 0, 0, 4'd0, 0, 0);
        step(1, 0, 1, 0, 4'd0, 0, 0);
        idle(3);
        chk("sob_open.lane0", 512'(seen_a[2][31:0]), 512'(0));
        chk("sob_open.next", 512'(seen_a[3][31:0]), 512'(1));
        chk("sob_open.err", 512'(ifb.out_err), 512'(1));

        // Reset with two beats in flight, then a fresh batch
        do_reset();
        step(1, 1, 0, 0, 4'd0, 0, 1);
        step(1, 0, 0, 0, 4'd0, 0, 1);
        do_reset();
        step(1, 1, 0, 0, 4'd0, 0, 0);
        step(1, 0, 0, 0, 4'd0, 0, 0);
        step(1, 0, 1, 0, 4'd0, 0, 0);
        idle(3);
        chk("post_rst.count", 512'(seen_a.size()), 512'(3));
        chk("post_rst.lane0", 512'(seen_a[0][31:0]), 512'(0));
        chk("post_rst.lane2", 512'(seen_a[2][31:0]), 512'(2));

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 200; n++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0, 4'($urandom), 1'($urandom), 1);
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
